// File: rtl/sram_wb_byte_en.sv
// Single-port SRAM behind a classic Wishbone slave. Each byte lane has its own write enable.
// After every reset, an optional sequencer clears the array, and an optional register stage can be added to reads.

module sram_wb_byte_en #(
    parameter int unsigned ADDR_BITS      = 8,
    parameter int unsigned DATA_BITS      = 32,
    parameter int unsigned RD_PIPE        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ADDR_BITS-1:0]   adr,
    input  logic [DATA_BITS-1:0]   dat_w,
    output logic [DATA_BITS-1:0]   dat_r,
    input  logic                   cyc,
    input  logic                   stb,
    input  logic                   we,
    input  logic [DATA_BITS/8-1:0] sel,
    output logic                   ack,
    output logic                   init_done
);

    localparam int unsigned NUM_BYTES = DATA_BITS / 8;
    localparam int unsigned DEPTH     = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {StClear, StIdle, StRdWait, StAck} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   clr_cnt_q, clr_cnt_d;
    logic                   ack_q, ack_d;
    logic                   init_done_q, init_done_d;
    logic [DATA_BITS-1:0]   dat_r_q, dat_r_d;
    logic [DATA_BITS-1:0]   rd_buf_q, rd_buf_d;

    logic [DATA_BITS-1:0]   mem [DEPTH];
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [DATA_BITS-1:0]   mem_wdata;
    logic [NUM_BYTES-1:0]   mem_be;
    logic [DATA_BITS-1:0]   mem_rdata;
    logic                   req;

    assign req       = cyc & stb;
    assign mem_rdata = mem[adr];

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ack_d       = 1'b0;
        init_done_d = init_done_q;
        dat_r_d     = dat_r_q;
        rd_buf_d    = rd_buf_q;
        mem_we      = 1'b0;
        mem_addr    = adr;
        mem_wdata   = dat_w;
        mem_be      = sel;

        unique case (state_q)
            StClear: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt_q;
                mem_wdata = '0;
                mem_be    = '1;
                clr_cnt_d = clr_cnt_q + ADDR_BITS'(1);
                if (&clr_cnt_q) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end
            end
            StIdle: begin
                // Also covers the no-clear build: usable from the first clock after reset.
                init_done_d = 1'b1;
                if (req) begin
                    if (we) begin
                        mem_we  = 1'b1;
                        ack_d   = 1'b1;
                        state_d = StAck;
                    end else if (RD_PIPE != 0) begin
                        rd_buf_d = mem_rdata;
                        state_d  = StRdWait;
                    end else begin
                        dat_r_d = mem_rdata;
                        ack_d   = 1'b1;
                        state_d = StAck;
                    end
                end
            end
            StRdWait: begin
                // A master that drops cyc here has abandoned the read.
                if (cyc) begin
                    dat_r_d = rd_buf_q;
                    ack_d   = 1'b1;
                    state_d = StAck;
                end else begin
                    state_d = StIdle;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
            clr_cnt_q   <= '0;
            ack_q       <= 1'b0;
            init_done_q <= 1'b0;
            dat_r_q     <= '0;
            rd_buf_q    <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ack_q       <= ack_d;
            init_done_q <= init_done_d;
            dat_r_q     <= dat_r_d;
            rd_buf_q    <= rd_buf_d;
        end
    end

    // The array has no reset; clearing is done by the sequencer.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign ack       = ack_q;
    assign dat_r     = dat_r_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_sram_wb_byte_en.sv
// Bench for sram_wb_byte_en with two instances: u0 is 256 words with reads returning in one cycle,
// and u1 is 16 words with RD_PIPE=1.

module tb_sram_wb_byte_en;

    logic        clock;
    logic        reset_n [2];
    logic [7:0]  adr     [2];
    logic [31:0] dat_w   [2];
    logic        cyc     [2];
    logic        stb     [2];
    logic        we      [2];
    logic [3:0]  sel     [2];

    logic [31:0] dat_r0, dat_r1;
    logic        ack0, ack1, init_done0, init_done1;

    sram_wb_byte_en #(
        .ADDR_BITS(8), .DATA_BITS(32), .RD_PIPE(0), .CLEAR_ON_RESET(1)
    ) u0 (
        .clock(clock), .reset_n(reset_n[0]), .adr(adr[0]), .dat_w(dat_w[0]),
        .dat_r(dat_r0), .cyc(cyc[0]), .stb(stb[0]), .we(we[0]), .sel(sel[0]),
        .ack(ack0), .init_done(init_done0)
    );

    sram_wb_byte_en #(
        .ADDR_BITS(4), .DATA_BITS(32), .RD_PIPE(1), .CLEAR_ON_RESET(1)
    ) u1 (
        .clock(clock), .reset_n(reset_n[1]), .adr(adr[1][3:0]), .dat_w(dat_w[1]),
        .dat_r(dat_r1), .cyc(cyc[1]), .stb(stb[1]), .we(we[1]), .sel(sel[1]),
        .ack(ack1), .init_done(init_done1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int          lat;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] last_rd [2];
    int          n_vec = 0;
    int          n_miss = 0;

    function automatic logic get_ack(input int p);
        return (p == 0) ? ack0 : ack1;
    endfunction

    function automatic logic [31:0] get_dat(input int p);
        return (p == 0) ? dat_r0 : dat_r1;
    endfunction

    function automatic logic get_init(input int p);
        return (p == 0) ? init_done0 : init_done1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic w, input logic [7:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cyc[p]   = 1'b1;
        stb[p]   = 1'b1;
        we[p]    = w;
        adr[p]   = a;
        dat_w[p] = d;
        sel[p]   = s;
    endtask

    task automatic idle_bus(input int p);
        cyc[p] = 1'b0;
        stb[p] = 1'b0;
        we[p]  = 1'b0;
    endtask

    // Called #1 after a posedge, with the request already on the bus.
    task automatic await_ack(input int p, input string name);
        exp_t e;
        int   lat;
        e   = sb.pop_front();
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!get_ack(p) && lat < 400);
        check({name, " ack"}, 32'(get_ack(p)), 32'd1);
        check({name, " init_done at ack"}, 32'(get_init(p)), 32'd1);
        if (e.lat > 0) check({name, " latency"}, lat, e.lat);
        if (e.rd) last_rd[p] = e.data;
        check({name, " dat_r"}, get_dat(p), last_rd[p]);
    endtask

    task automatic do_req(input int p, input logic w, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] rd_exp, input int lat,
                          input string name);
        drive(p, w, a, d, s);
        sb.push_back('{lat, !w, rd_exp});
        await_ack(p, name);
        idle_bus(p);
        @(posedge clock);
        #1;
        check({name, " ack width"}, 32'(get_ack(p)), 32'd0);
    endtask

    task automatic do_reset(input int p, input string name);
        reset_n[p] = 1'b0;
        #1;
        check({name, " ack in reset"}, 32'(get_ack(p)), 32'd0);
        check({name, " dat_r in reset"}, get_dat(p), 32'd0);
        check({name, " init_done in reset"}, 32'(get_init(p)), 32'd0);
        last_rd[p] = '0;
        @(negedge clock);
        reset_n[p] = 1'b1;
    endtask

    task automatic wait_init(input int p, input int exp, input string name);
        int n;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!get_init(p) && n < 400);
        check(name, n, exp);
    endtask

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1'b1, 8'h05, 32'h11223344, 4'hF,    32'h0};
        vecs[1]  = '{1'b1, 8'h05, 32'hAABBCCDD, 4'b0101, 32'h0};
        vecs[2]  = '{1'b0, 8'h05, 32'h0,        4'hF,    32'h11BB33DD};
        vecs[3]  = '{1'b1, 8'h06, 32'h55667788, 4'hF,    32'h0};
        vecs[4]  = '{1'b1, 8'h06, 32'hDEADBEEF, 4'h0,    32'h0};
        vecs[5]  = '{1'b0, 8'h06, 32'h0,        4'hF,    32'h55667788};
        vecs[6]  = '{1'b1, 8'h80, 32'h01020304, 4'b1000, 32'h0};
        vecs[7]  = '{1'b0, 8'h80, 32'h0,        4'hF,    32'h01000000};
        vecs[8]  = '{1'b1, 8'h80, 32'hFFFFFFFF, 4'b0110, 32'h0};
        vecs[9]  = '{1'b0, 8'h80, 32'h0,        4'hF,    32'h01FFFF00};
        vecs[10] = '{1'b0, 8'h00, 32'h0,        4'hF,    32'h00000000};
        vecs[11] = '{1'b0, 8'h05, 32'h0,        4'hF,    32'h11BB33DD};
        vecs[12] = '{1'b1, 8'h07, 32'h0BADF00D, 4'hF,    32'h0};

        for (int p = 0; p < 2; p++) begin
            reset_n[p] = 1'b0;
            adr[p]     = '0;
            dat_w[p]   = '0;
            sel[p]     = '0;
            last_rd[p] = '0;
            idle_bus(p);
        end

        #12;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("u%0d reset ack", p), 32'(get_ack(p)), 32'd0);
            check($sformatf("u%0d reset dat_r", p), get_dat(p), 32'd0);
            check($sformatf("u%0d reset init_done", p), 32'(get_init(p)), 32'd0);
        end

        // u1: clear timing, clear contents, then a request issued during a second clear
        @(negedge clock);
        reset_n[1] = 1'b1;
        wait_init(1, 16, "u1 clear length");
        for (int i = 0; i < 16; i++) do_req(1, 1'b0, 8'(i), '0, 4'hF, 32'h0, 2, $sformatf("u1 clr rd%0d", i));
        for (int i = 0; i < 16; i++) do_req(1, 1'b1, 8'(i), 32'hFFFFFFFF, 4'hF, '0, 1, $sformatf("u1 fill%0d", i));
        do_reset(1, "u1 rst2");
        @(posedge clock);
        @(posedge clock);
        #1;
        do_req(1, 1'b0, 8'h03, '0, 4'hF, 32'h0, 16, "u1 rd during clear");
        for (int i = 0; i < 16; i++) do_req(1, 1'b0, 8'(i), '0, 4'hF, 32'h0, 2, $sformatf("u1 reclr rd%0d", i));

        // u1: abort in RD_WAIT, then reset in RD_WAIT
        do_req(1, 1'b1, 8'h05, 32'h11223344, 4'hF, '0, 1, "u1 wr5");
        do_req(1, 1'b1, 8'h06, 32'hCAFEF00D, 4'hF, '0, 1, "u1 wr6");
        do_req(1, 1'b0, 8'h05, '0, 4'hF, 32'h11223344, 2, "u1 rd5");
        drive(1, 1'b0, 8'h06, '0, 4'hF);
        @(posedge clock);
        #1;
        idle_bus(1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            check($sformatf("u1 abort ack c%0d", i), 32'(ack1), 32'd0);
            check($sformatf("u1 abort dat_r c%0d", i), dat_r1, 32'h11223344);
        end
        drive(1, 1'b0, 8'h06, '0, 4'hF);
        @(posedge clock);
        #1;
        idle_bus(1);
        do_reset(1, "u1 midop rst");
        wait_init(1, 16, "u1 midop clear length");
        do_req(1, 1'b0, 8'h06, '0, 4'hF, 32'h0, 2, "u1 rd6 after rst");

        // u0: 256-word clear, then table of byte-enable accesses
        @(negedge clock);
        reset_n[0] = 1'b1;
        wait_init(0, 256, "u0 clear length");
        for (int i = 0; i < 13; i++) begin
            do_req(0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp, 1,
                   $sformatf("u0 vec%0d", i));
        end

        // u0: stb held through ack, alternating write/read at 0xFF
        drive(0, 1'b1, 8'hFF, 32'hA5A5A5A5, 4'hF);
        sb.push_back('{1, 1'b0, 32'h0});
        await_ack(0, "b2b wr0");
        drive(0, 1'b0, 8'hFF, '0, 4'hF);
        sb.push_back('{2, 1'b1, 32'hA5A5A5A5});
        await_ack(0, "b2b rd0");
        drive(0, 1'b1, 8'hFF, 32'h5A5A5A5A, 4'hF);
        sb.push_back('{2, 1'b0, 32'h0});
        await_ack(0, "b2b wr1");
        drive(0, 1'b0, 8'hFF, '0, 4'hF);
        sb.push_back('{2, 1'b1, 32'h5A5A5A5A});
        await_ack(0, "b2b rd1");
        idle_bus(0);
        @(posedge clock);
        #1;
        check("b2b final ack width", 32'(ack0), 32'd0);

        do_req(0, 1'b1, 8'hFF, 32'h12345678, 4'h0, '0, 1, "u0 sel0 wr");
        do_req(0, 1'b0, 8'hFF, '0, 4'hF, 32'h5A5A5A5A, 1, "u0 sel0 rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
